lcd_bus_decoder: RTL and testbench

Passive decoder for the HD44780-style character-LCD bus driven by the calculator's LCD controller (`lcd_e`, `lcd_rs`, `lcd_rw`, `lcd_data`). It decodes each E-strobe into an instruction or data write and tracks the address counter and display flags. It mirrors the 2×16 display contents into a 32-byte shadow RAM that a host or test logic reads back. It never drives the LCD bus. It sits alongside the controller, both as an on-chip display mirror and as the bench-side checker for the controller.

---
 rtl/lcd_pkg.sv | 43 ++++
 rtl/lcd_bus_decoder_if.sv | 9 +
 rtl/lcd_strobe_sync.sv | 32 +++
 rtl/lcd_bus_decoder.sv | 111 +++++++++++
 tb/tb_lcd_bus_decoder.sv | 156 +++++++++++++++
 5 files changed

// File: rtl/lcd_pkg.sv
// lcd_pkg: shared HD44780 opcodes, calculator ASCII set, DDRAM line/wrap addresses and decode helpers
package lcd_pkg;
  localparam logic [7:0] OP_SET_DDRAM = 8'h80;
  localparam logic [7:0] OP_SET_CGRAM = 8'h40;
  localparam logic [7:0] OP_FUNC      = 8'h20;
  localparam logic [7:0] OP_SHIFT     = 8'h10;
  localparam logic [7:0] OP_DISP      = 8'h08;
  localparam logic [7:0] OP_ENTRY     = 8'h04;
  localparam logic [7:0] OP_HOME      = 8'h02;
  localparam logic [7:0] OP_CLEAR     = 8'h01;

  localparam logic [7:0] CH_0     = 8'h30;
  localparam logic [7:0] CH_9     = 8'h39;
  localparam logic [7:0] CH_PLUS  = 8'h2B;
  localparam logic [7:0] CH_MINUS = 8'h2D;
  localparam logic [7:0] CH_EQ    = 8'h3D;
  localparam logic [7:0] CH_SPACE = 8'h20;

  localparam logic [6:0] LINE0 = 7'h00;
  localparam logic [6:0] LINE1 = 7'h40;
  localparam logic [6:0] WRAP0 = 7'h27;
  localparam logic [6:0] WRAP1 = 7'h67;

  typedef enum logic [3:0] {I_DDRAM, I_CGRAM, I_FUNC, I_SHIFT, I_DISP, I_ENTRY, I_HOME, I_CLEAR, I_NOP} instr_e;
  typedef enum logic {FILL_IDLE, FILL_RUN} fill_state_e;

  function automatic instr_e decode_instr(input logic [7:0] d);
    return |(d & OP_SET_DDRAM) ? I_DDRAM :
           |(d & OP_SET_CGRAM) ? I_CGRAM :
           |(d & OP_FUNC)      ? I_FUNC  :
           |(d & OP_SHIFT)     ? I_SHIFT :
           |(d & OP_DISP)      ? I_DISP  :
           |(d & OP_ENTRY)     ? I_ENTRY :
           |(d & OP_HOME)      ? I_HOME  :
           |(d & OP_CLEAR)     ? I_CLEAR : I_NOP;
  endfunction

  // Two-line mode address counter: lines occupy 0x00-0x27 and 0x40-0x67
  function automatic logic [6:0] ac_step(input logic [6:0] a, input logic inc);
    return inc ? (a == WRAP0 ? LINE1 : a == WRAP1 ? LINE0 : a + 7'd1)
               : (a == LINE0 ? WRAP1 : a == LINE1 ? WRAP0 : a - 7'd1);
  endfunction
endpackage

// File: rtl/lcd_bus_decoder_if.sv
// lcd_bus_decoder_if: HD44780 character-LCD bus as driven by the LCD controller
interface lcd_bus_decoder_if;
  logic       lcd_e;
  logic       lcd_rs;
  logic       lcd_rw;
  logic [7:0] lcd_data;
  modport master (output lcd_e, lcd_rs, lcd_rw, lcd_data);
  modport slave  (input  lcd_e, lcd_rs, lcd_rw, lcd_data);
endinterface

// File: rtl/lcd_strobe_sync.sv
// lcd_strobe_sync: synchronizes E, flags its falling edge and holds the bus values seen while E was high
module lcd_strobe_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       e,
  input  logic       rs,
  input  logic       rw,
  input  logic [7:0] data,
  output logic       fall,
  output logic       cap_rs,
  output logic       cap_rw,
  output logic [7:0] cap_data
);
  logic [SYNC_STAGES-1:0] sync;
  logic e_s, e_d;
  assign e_s  = sync[SYNC_STAGES-1];
  assign fall = e_d & ~e_s;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      sync     <= '0;
      e_d      <= 1'b0;
      cap_rs   <= 1'b0;
      cap_rw   <= 1'b0;
      cap_data <= '0;
    end else begin
      sync <= SYNC_STAGES'({sync, e});
      e_d  <= e_s;
      if (e_s) {cap_rs, cap_rw, cap_data} <= {rs, rw, data};
    end
endmodule

// File: rtl/lcd_bus_decoder.sv
// lcd_bus_decoder: passive HD44780 bus decoder tracking AC/flags and mirroring the 2x16 display into a shadow RAM
module lcd_bus_decoder
  import lcd_pkg::*;
#(
  parameter int         SYNC_STAGES = 2,
  parameter logic [7:0] FILL_CHAR   = 8'h20
) (
  input  logic                clk,
  input  logic                rst,
  lcd_bus_decoder_if.slave    lcd,
  input  logic [4:0]          rd_addr,
  output logic [7:0]          rd_data,
  output logic                cmd_valid,
  output logic                cmd_rs,
  output logic [7:0]          cmd_data,
  output logic [6:0]          ac,
  output logic                disp_on,
  output logic                cursor_on,
  output logic                blink_on,
  output logic                entry_inc,
  output logic [2:0]          func_reg,
  output logic                busy,
  output logic                ovr_err,
  output logic                rw_err
);
  logic       fall, cap_rs, cap_rw;
  logic [7:0] cap_data;
  instr_e     op;
  fill_state_e state, state_n;
  logic [4:0] idx;
  logic [7:0] shadow [32];
  logic       accept, start, we;
  logic [4:0] waddr;
  logic [7:0] wdata;

  lcd_strobe_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk(clk), .rst(rst), .e(lcd.lcd_e), .rs(lcd.lcd_rs), .rw(lcd.lcd_rw), .data(lcd.lcd_data),
    .fall(fall), .cap_rs(cap_rs), .cap_rw(cap_rw), .cap_data(cap_data)
  );

  assign op     = decode_instr(cap_data);
  assign busy   = state == FILL_RUN;
  assign accept = fall & ~cap_rw & ~busy;
  assign start  = accept & ~cap_rs & (op == I_CLEAR);

  // One shadow write port: fill and data writes never coincide since writes are dropped while busy
  always_comb begin
    we    = busy | (accept & cap_rs & (ac[5:4] == 2'b00));
    waddr = busy ? idx : {ac[6], ac[3:0]};
    wdata = busy ? FILL_CHAR : cap_data;
  end

  always_comb begin
    state_n = state;
    state_n = busy ? (idx == 5'd31 ? FILL_IDLE : FILL_RUN) : (start ? FILL_RUN : FILL_IDLE);
  end

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= FILL_IDLE;
      idx   <= '0;
    end else begin
      state <= state_n;
      idx   <= busy ? idx + 5'd1 : 5'd0;
    end

  always_ff @(posedge clk)
    if (we) shadow[waddr] <= wdata;

  always_ff @(posedge clk or posedge rst)
    if (rst) rd_data <= '0;
    else rd_data <= shadow[rd_addr];

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      cmd_valid <= 1'b0;
      cmd_rs    <= 1'b0;
      cmd_data  <= '0;
      ac        <= '0;
      disp_on   <= 1'b0;
      cursor_on <= 1'b0;
      blink_on  <= 1'b0;
      entry_inc <= 1'b1;
      func_reg  <= '0;
      ovr_err   <= 1'b0;
      rw_err    <= 1'b0;
    end else begin
      cmd_valid <= accept;
      if (fall & cap_rw) rw_err <= 1'b1;
      if (fall & ~cap_rw & busy) ovr_err <= 1'b1;
      if (accept) begin
        cmd_rs   <= cap_rs;
        cmd_data <= cap_data;
        if (cap_rs) ac <= ac_step(ac, entry_inc);
        else
          case (op)
            I_DDRAM: ac <= cap_data[6:0];
            I_FUNC:  func_reg <= cap_data[4:2];
            I_SHIFT: if (!cap_data[3]) ac <= ac_step(ac, cap_data[2]);
            I_DISP:  {disp_on, cursor_on, blink_on} <= cap_data[2:0];
            I_ENTRY: entry_inc <= cap_data[1];
            I_HOME:  ac <= '0;
            I_CLEAR: begin
              ac        <= '0;
              entry_inc <= 1'b1;
            end
            default: ;
          endcase
      end
    end
endmodule

// File: tb/tb_lcd_bus_decoder.sv
// tb_lcd_bus_decoder: scoreboard bench driving HD44780 strobes and checking decoded commands, state and shadow RAM
module tb_lcd_bus_decoder;
  localparam int SYNC = 2;
  logic clk = 0, rst = 1;
  logic [4:0] rd_addr = '0;
  logic [7:0] rd_data, cmd_data, v;
  logic cmd_valid, cmd_rs, disp_on, cursor_on, blink_on, entry_inc, busy, ovr_err, rw_err;
  logic [6:0] ac;
  logic [2:0] func_reg;
  int passed = 0, total = 0, cyc = 0, fall_cyc = 0, busy_cyc = 0, b0;
  logic [8:0] q[$];

  lcd_bus_decoder_if lcd();

  lcd_bus_decoder #(.SYNC_STAGES(SYNC), .FILL_CHAR(8'h20)) dut (
    .clk(clk), .rst(rst), .lcd(lcd), .rd_addr(rd_addr), .rd_data(rd_data),
    .cmd_valid(cmd_valid), .cmd_rs(cmd_rs), .cmd_data(cmd_data), .ac(ac),
    .disp_on(disp_on), .cursor_on(cursor_on), .blink_on(blink_on), .entry_inc(entry_inc),
    .func_reg(func_reg), .busy(busy), .ovr_err(ovr_err), .rw_err(rw_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  always @(negedge clk) if (busy) busy_cyc++;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  always @(negedge clk)
    if (cmd_valid) begin
      logic [9:0] e;
      e = q.size() > 0 ? {1'b0, q.pop_front()} : 10'h3FF;
      chk("cmd", {22'd0, 1'b0, cmd_rs, cmd_data}, {22'd0, e});
      chk("cmd_latency", cyc - fall_cyc, SYNC + 1);
    end

  task automatic strobe(input logic rs, input logic rw, input logic [7:0] d, input logic exp_cmd);
    @(negedge clk);
    lcd.lcd_rs = rs;
    lcd.lcd_rw = rw;
    lcd.lcd_data = d;
    lcd.lcd_e = 1'b1;
    if (exp_cmd) q.push_back({rs, d});
    repeat (4) @(negedge clk);
    lcd.lcd_e = 1'b0;
    fall_cyc = cyc;
    repeat (5) @(negedge clk);
  endtask

  task automatic chk_rd(input string tag, input logic [4:0] a, input logic [7:0] exp);
    @(negedge clk);
    rd_addr = a;
    @(negedge clk);
    chk(tag, {24'd0, rd_data}, {24'd0, exp});
  endtask

  task automatic wait_fill();
    for (int i = 0; i < 100 && busy; i++) @(negedge clk);
    chk("fill_done", {31'd0, busy}, 0);
  endtask

  initial begin
    lcd.lcd_e = 0; lcd.lcd_rs = 0; lcd.lcd_rw = 0; lcd.lcd_data = 0;
    repeat (3) @(negedge clk);
    chk("rst_ac", {25'd0, ac}, 0);
    chk("rst_entry", {31'd0, entry_inc}, 1);
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_cmd_valid", {31'd0, cmd_valid}, 0);
    chk("rst_rd_data", {24'd0, rd_data}, 0);
    rst = 0;
    strobe(0, 0, 8'h3C, 1);
    strobe(0, 0, 8'h0C, 1);
    strobe(0, 0, 8'h06, 1);
    chk("func_reg", {29'd0, func_reg}, 3'b111);
    chk("disp_flags", {29'd0, disp_on, cursor_on, blink_on}, 3'b100);
    chk("entry_inc", {31'd0, entry_inc}, 1);
    strobe(0, 0, 8'h80, 1);
    strobe(1, 0, 8'h31, 1);
    strobe(1, 0, 8'h2B, 1);
    strobe(1, 0, 8'h32, 1);
    chk("ac_line0", {25'd0, ac}, 7'h03);
    chk_rd("sh0", 5'd0, 8'h31);
    chk_rd("sh1", 5'd1, 8'h2B);
    chk_rd("sh2", 5'd2, 8'h32);
    strobe(0, 0, 8'hC0, 1);
    strobe(1, 0, 8'h57, 1);
    chk("ac_line1", {25'd0, ac}, 7'h41);
    chk_rd("sh16", 5'd16, 8'h57);
    b0 = busy_cyc;
    strobe(0, 0, 8'h01, 1);
    wait_fill();
    chk("busy_len", busy_cyc - b0, 32);
    chk("clr_ac", {25'd0, ac}, 0);
    for (int i = 0; i < 32; i++) chk_rd($sformatf("fill%0d", i), 5'(i), 8'h20);
    strobe(0, 0, 8'h85, 1);
    strobe(0, 0, 8'h01, 1);
    strobe(1, 0, 8'h41, 0);
    wait_fill();
    chk("ovr_err", {31'd0, ovr_err}, 1);
    chk("ovr_ac", {25'd0, ac}, 0);
    chk_rd("ovr_sh0", 5'd0, 8'h20);
    strobe(0, 0, 8'hA7, 1);
    strobe(1, 0, 8'h41, 1);
    chk("wrap_27", {25'd0, ac}, 7'h40);
    chk_rd("wrap_nowrite", 5'd7, 8'h20);
    strobe(0, 0, 8'h80, 1);
    strobe(0, 0, 8'h04, 1);
    strobe(1, 0, 8'h42, 1);
    chk("entry_dec", {31'd0, entry_inc}, 0);
    chk("wrap_00", {25'd0, ac}, 7'h67);
    chk_rd("dec_sh0", 5'd0, 8'h42);
    strobe(0, 0, 8'hC0, 1);
    strobe(1, 0, 8'h43, 1);
    chk("wrap_40", {25'd0, ac}, 7'h27);
    strobe(0, 0, 8'h14, 1);
    chk("shift_r", {25'd0, ac}, 7'h40);
    strobe(0, 0, 8'h18, 1);
    chk("disp_shift", {25'd0, ac}, 7'h40);
    strobe(0, 0, 8'h02, 1);
    chk("home", {25'd0, ac}, 0);
    strobe(0, 1, 8'h01, 0);
    chk("rw_err", {31'd0, rw_err}, 1);
    chk("rw_no_clear", {31'd0, busy}, 0);
    strobe(0, 0, 8'h06, 1);
    strobe(0, 0, 8'hCF, 1);
    strobe(1, 0, 8'h58, 1);
    chk_rd("sh31", 5'd31, 8'h58);
    strobe(0, 0, 8'h01, 1);
    repeat (2) @(negedge clk);
    chk("mid_busy", {31'd0, busy}, 1);
    rst = 1;
    #1;
    chk("rst_mid_busy", {31'd0, busy}, 0);
    chk("rst_mid_ac", {25'd0, ac}, 0);
    chk("rst_mid_func", {29'd0, func_reg}, 0);
    chk("rst_mid_disp", {31'd0, disp_on}, 0);
    chk("rst_mid_errs", {30'd0, ovr_err, rw_err}, 0);
    chk("rst_mid_rd", {24'd0, rd_data}, 0);
    @(negedge clk);
    rst = 0;
    chk_rd("abort_sh31", 5'd31, 8'h58);
    chk_rd("abort_sh0", 5'd0, 8'h20);
    chk("q_empty", q.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end
endmodule
